reg_read_scheduler: RTL and testbench

- Sequences register-read instructions from the instruction data buffer: decodes the register address and strobes exactly one read-register source.
- Waits for that source's 32-bit response, with a timeout, then serializes the word LSB-first as 4 bytes to the SPI transmit byte buffer under a valid/ready handshake.
- It is the single owner of the shared read-register response path and the SPI byte path for register reads.

---
 rtl/reg_read_scheduler_pkg.sv | 18 +
 rtl/reg_read_scheduler_if.sv | 31 +++
 rtl/reg_word_serializer.sv | 59 +++++
 rtl/reg_read_scheduler.sv | 131 +++++++++++++
 tb/tb_reg_read_scheduler.sv | 281 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_read_scheduler_pkg.sv
// Shared types and constants for the register-read scheduler slice.
package reg_read_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_SEND = 2'd3
  } state_t;

  // Register addresses are word aligned; each word leaves as 4 bytes.
  localparam int ADDR_STRIDE    = 4;
  localparam int BYTES_PER_WORD = 4;

  // Marker word sent instead of data on a bad address or timeout.
  localparam logic [31:0] DEFAULT_BAD_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/reg_read_scheduler_if.sv
// Instruction, read-register and SPI byte signals of the scheduler.
interface reg_read_scheduler_if #(
  parameter int NUM_REGS = 4
);
  logic                instr_valid;
  logic [7:0]          reg_addr;
  logic [NUM_REGS-1:0] rd_strobe;
  logic                rd_valid;
  logic [31:0]         rd_data;
  logic [7:0]          byte_out;
  logic                byte_out_valid;
  logic                byte_out_ready;
  logic                busy;
  logic                err_bad_addr;
  logic                err_timeout;
  logic                drop_pulse;

  // Scheduler side.
  modport slave (
    input  instr_valid, reg_addr, rd_valid, rd_data, byte_out_ready,
    output rd_strobe, byte_out, byte_out_valid, busy,
           err_bad_addr, err_timeout, drop_pulse
  );

  // Instruction source / register sources / SPI buffer side.
  modport master (
    output instr_valid, reg_addr, rd_valid, rd_data, byte_out_ready,
    input  rd_strobe, byte_out, byte_out_valid, busy,
           err_bad_addr, err_timeout, drop_pulse
  );
endinterface

// File: rtl/reg_word_serializer.sv
// Sends a 32-bit word LSB-first as bytes over a valid/ready handshake.
// o_done is high in the cycle the last byte is accepted.
module reg_word_serializer
  import reg_read_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_load,
  input  logic [31:0] i_word,
  input  logic        i_ready,
  output logic [7:0]  o_byte,
  output logic        o_valid,
  output logic        o_done
);

  localparam int IDX_W = $clog2(BYTES_PER_WORD);

  logic [31:0]      r_word;
  logic [IDX_W-1:0] r_idx;
  logic [7:0]       r_byte;
  logic             r_valid;

  logic             w_accept;
  logic             w_last;
  logic [IDX_W-1:0] w_idx_nxt;

  assign w_accept  = r_valid & i_ready;
  assign w_last    = (r_idx == IDX_W'(BYTES_PER_WORD - 1));
  assign w_idx_nxt = r_idx + IDX_W'(1);

  assign o_byte  = r_byte;
  assign o_valid = r_valid;
  assign o_done  = w_accept & w_last;

  // Byte register holds while not accepted; next byte is preloaded on accept.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word  <= '0;
      r_idx   <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_word  <= i_word;
      r_idx   <= '0;
      r_byte  <= i_word[7:0];
      r_valid <= 1'b1;
    end else if (w_accept) begin
      if (w_last) begin
        r_idx   <= '0;
        r_byte  <= '0;
        r_valid <= 1'b0;
      end else begin
        r_idx  <= w_idx_nxt;
        r_byte <= r_word[{w_idx_nxt, 3'b000} +: 8];
      end
    end
  end

endmodule

// File: rtl/reg_read_scheduler.sv
// Register-read scheduler: decodes an instruction address, strobes one
// register source, waits (bounded) for its reply and streams it as bytes.
module reg_read_scheduler
  import reg_read_pkg::*;
#(
  parameter int          NUM_REGS       = 4,
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [31:0] BAD_WORD       = DEFAULT_BAD_WORD
)(
  input  logic                 sysClk,
  input  logic                 rst_n,
  reg_read_scheduler_if.slave  bus
);

  localparam int ALIGN_BITS = $clog2(ADDR_STRIDE);

  state_t              r_state, w_state_nxt;
  logic [NUM_REGS-1:0] r_strobe, w_strobe_nxt;
  logic [7:0]          r_timer, w_timer_nxt;
  logic                r_busy;
  logic                r_err_bad, w_err_bad_nxt;
  logic                r_err_to, w_err_to_nxt;
  logic                r_drop, w_drop_nxt;

  logic                w_addr_ok;
  logic                w_load;
  logic [31:0]         w_load_word;
  logic                w_ser_done;
  logic [7:0]          w_byte;
  logic                w_byte_valid;

  assign w_addr_ok = (bus.reg_addr[ALIGN_BITS-1:0] == '0) &&
                     (int'(bus.reg_addr[7:ALIGN_BITS]) < NUM_REGS);

  // Next state, one-cycle pulses, timer and serializer load.
  always_comb begin
    w_state_nxt   = r_state;
    w_strobe_nxt  = '0;
    w_timer_nxt   = r_timer;
    w_err_bad_nxt = 1'b0;
    w_err_to_nxt  = 1'b0;
    w_drop_nxt    = bus.instr_valid && (r_state != S_IDLE);
    w_load        = 1'b0;
    w_load_word   = BAD_WORD;

    case (r_state)
      S_IDLE: begin
        if (bus.instr_valid) begin
          if (w_addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++)
              w_strobe_nxt[i] = (int'(bus.reg_addr[7:ALIGN_BITS]) == i);
            w_state_nxt = S_REQ;
          end else begin
            w_load        = 1'b1;
            w_err_bad_nxt = 1'b1;
            w_state_nxt   = S_SEND;
          end
        end
      end
      S_REQ: begin
        w_timer_nxt = '0;
        if (bus.rd_valid) begin
          w_load      = 1'b1;
          w_load_word = bus.rd_data;
          w_state_nxt = S_SEND;
        end else begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        // A reply in the expiry cycle still counts as a good reply.
        if (bus.rd_valid) begin
          w_load      = 1'b1;
          w_load_word = bus.rd_data;
          w_state_nxt = S_SEND;
        end else if (r_timer == 8'(TIMEOUT_CYCLES - 1)) begin
          w_load       = 1'b1;
          w_err_to_nxt = 1'b1;
          w_state_nxt  = S_SEND;
        end else begin
          w_timer_nxt = r_timer + 8'd1;
        end
      end
      S_SEND: begin
        if (w_ser_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and registered outputs; busy tracks the registered state.
  always_ff @(posedge sysClk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_strobe  <= '0;
      r_timer   <= '0;
      r_busy    <= 1'b0;
      r_err_bad <= 1'b0;
      r_err_to  <= 1'b0;
      r_drop    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_strobe  <= w_strobe_nxt;
      r_timer   <= w_timer_nxt;
      r_busy    <= (w_state_nxt != S_IDLE);
      r_err_bad <= w_err_bad_nxt;
      r_err_to  <= w_err_to_nxt;
      r_drop    <= w_drop_nxt;
    end
  end

  reg_word_serializer u_ser (
    .i_clk   (sysClk),
    .i_rst_n (rst_n),
    .i_load  (w_load),
    .i_word  (w_load_word),
    .i_ready (bus.byte_out_ready),
    .o_byte  (w_byte),
    .o_valid (w_byte_valid),
    .o_done  (w_ser_done)
  );

  assign bus.rd_strobe      = r_strobe;
  assign bus.byte_out       = w_byte;
  assign bus.byte_out_valid = w_byte_valid;
  assign bus.busy           = r_busy;
  assign bus.err_bad_addr   = r_err_bad;
  assign bus.err_timeout    = r_err_to;
  assign bus.drop_pulse     = r_drop;

endmodule

// File: tb/tb_reg_read_scheduler.sv
// Directed bench for reg_read_scheduler with a byte scoreboard.
module tb_reg_read_scheduler;

  localparam int          NREG = 4;
  localparam int          TOUT = 20;
  localparam logic [31:0] BADW = 32'hDEAD_BEEF;

  logic sysClk = 1'b0;
  logic rst_n;

  reg_read_scheduler_if #(.NUM_REGS(NREG)) bus ();

  reg_read_scheduler #(
    .NUM_REGS       (NREG),
    .TIMEOUT_CYCLES (TOUT),
    .BAD_WORD       (BADW)
  ) dut (
    .sysClk (sysClk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  always #5 sysClk = ~sysClk;

  int         n_pass  = 0;
  int         n_total = 0;
  int         n_fail  = 0;
  int         n_xfer  = 0;
  logic [7:0] exp_q[$];
  logic       held_vld = 1'b0;
  logic [7:0] held_byte = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic send_instr(input logic [7:0] a);
    bus.instr_valid = 1'b1;
    bus.reg_addr    = a;
    tick();
    bus.instr_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy && n < 50) begin
      tick();
      n++;
    end
    chk(tag, bus.busy, 0);
    chk({tag, "_q"}, exp_q.size(), 0);
  endtask

  // Scoreboard: every accepted byte is popped and compared; held bytes must not move.
  always @(negedge sysClk) begin
    if (bus.byte_out_valid) begin
      if (held_vld) chk("hold_stable", bus.byte_out, held_byte);
      if (bus.byte_out_ready) begin
        n_xfer++;
        held_vld = 1'b0;
        if (exp_q.size() == 0) chk("extra_byte", exp_q.size(), 1);
        else chk("byte", bus.byte_out, exp_q.pop_front());
      end else begin
        held_vld  = 1'b1;
        held_byte = bus.byte_out;
      end
    end else begin
      held_vld = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    logic [7:0] bad_addrs [2] = '{8'h06, 8'h10};
    int         x0;

    rst_n              = 1'b0;
    bus.instr_valid    = 1'b0;
    bus.reg_addr       = '0;
    bus.rd_valid       = 1'b0;
    bus.rd_data        = '0;
    bus.byte_out_ready = 1'b1;
    tick();
    tick();

    // Reset state
    chk("rst_strobe", bus.rd_strobe, 0);
    chk("rst_byte", bus.byte_out, 0);
    chk("rst_valid", bus.byte_out_valid, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_errs", {bus.err_bad_addr, bus.err_timeout, bus.drop_pulse}, 0);
    rst_n = 1'b1;
    tick();

    // Stray rd_valid in IDLE is ignored
    bus.rd_valid = 1'b1;
    bus.rd_data  = 32'h1234_5678;
    tick();
    bus.rd_valid = 1'b0;
    chk("idle_rdv_busy", bus.busy, 0);
    chk("idle_rdv_valid", bus.byte_out_valid, 0);

    // Addr 0x04, reply at cycle 3, ready high
    push_word(32'h1122_3344);
    send_instr(8'h04);
    chk("t1_strobe", bus.rd_strobe, 4'b0010);
    chk("t1_busy", bus.busy, 1);
    tick();
    chk("t1_strobe_off", bus.rd_strobe, 0);
    tick();
    bus.rd_valid = 1'b1;
    bus.rd_data  = 32'h1122_3344;
    tick();
    bus.rd_valid = 1'b0;
    chk("t1_first_valid", bus.byte_out_valid, 1);
    chk("t1_first_byte", bus.byte_out, 8'h44);
    tick();
    tick();
    tick();
    tick();
    chk("t1_busy_c8", bus.busy, 0);
    chk("t1_valid_c8", bus.byte_out_valid, 0);
    chk("t1_q", exp_q.size(), 0);

    // Same transaction with ready toggling
    push_word(32'h1122_3344);
    send_instr(8'h04);
    tick();
    tick();
    bus.rd_valid = 1'b1;
    bus.rd_data  = 32'h1122_3344;
    tick();
    bus.rd_valid = 1'b0;
    x0 = n_xfer;
    for (int i = 0; i < 7; i++) begin
      bus.byte_out_ready = pat[i];
      tick();
    end
    chk("t2_busy", bus.busy, 0);
    chk("t2_xfers", n_xfer - x0, 4);
    chk("t2_q", exp_q.size(), 0);
    bus.byte_out_ready = 1'b1;

    // Bad addresses: unaligned, then out of range
    for (int k = 0; k < 2; k++) begin
      push_word(BADW);
      send_instr(bad_addrs[k]);
      chk("t3_err_bad", bus.err_bad_addr, 1);
      chk("t3_no_strobe", bus.rd_strobe, 0);
      chk("t3_valid", bus.byte_out_valid, 1);
      chk("t3_byte0", bus.byte_out, 8'hEF);
      tick();
      chk("t3_err_bad_off", bus.err_bad_addr, 0);
      wait_idle("t3_idle");
    end

    // Timeout with no reply
    push_word(BADW);
    send_instr(8'h00);
    chk("t4_strobe", bus.rd_strobe, 4'b0001);
    for (int c = 2; c <= TOUT + 1; c++) begin
      tick();
      chk("t4_no_timeout_yet", bus.err_timeout, 0);
    end
    tick();
    chk("t4_err_timeout", bus.err_timeout, 1);
    chk("t4_byte0", bus.byte_out, 8'hEF);
    tick();
    chk("t4_err_timeout_off", bus.err_timeout, 0);
    wait_idle("t4_idle");

    // Reply on the expiry cycle wins over the timeout
    push_word(32'hCAFE_1234);
    send_instr(8'h00);
    repeat (TOUT) tick();
    bus.rd_valid = 1'b1;
    bus.rd_data  = 32'hCAFE_1234;
    tick();
    bus.rd_valid = 1'b0;
    chk("t4b_no_timeout", bus.err_timeout, 0);
    chk("t4b_valid", bus.byte_out_valid, 1);
    chk("t4b_byte0", bus.byte_out, 8'h34);
    wait_idle("t4b_idle");

    // Drops during WAIT and SEND, then accept on first IDLE cycle
    push_word(32'h5566_7788);
    send_instr(8'h08);
    tick();
    bus.instr_valid = 1'b1;
    bus.reg_addr    = 8'h0C;
    tick();
    bus.instr_valid = 1'b0;
    chk("t5_drop_wait", bus.drop_pulse, 1);
    chk("t5_drop_no_strobe", bus.rd_strobe, 0);
    bus.rd_valid = 1'b1;
    bus.rd_data  = 32'h5566_7788;
    tick();
    bus.rd_valid = 1'b0;
    chk("t5_drop_off", bus.drop_pulse, 0);
    bus.instr_valid = 1'b1;
    tick();
    bus.instr_valid = 1'b0;
    chk("t5_drop_send", bus.drop_pulse, 1);
    tick();
    tick();
    tick();
    chk("t5_idle_c8", bus.busy, 0);
    push_word(32'h0BAD_F00D);
    send_instr(8'h0C);
    chk("t5_accept_strobe", bus.rd_strobe, 4'b1000);
    chk("t5_accept_no_drop", bus.drop_pulse, 0);
    bus.rd_valid = 1'b1;
    bus.rd_data  = 32'h0BAD_F00D;
    tick();
    bus.rd_valid = 1'b0;
    chk("t5_req_reply_byte", bus.byte_out, 8'h0D);
    wait_idle("t5_idle");

    // Reset after two bytes accepted
    exp_q.push_back(8'h04);
    exp_q.push_back(8'h03);
    send_instr(8'h00);
    bus.rd_valid = 1'b1;
    bus.rd_data  = 32'h0102_0304;
    tick();
    bus.rd_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", bus.byte_out_valid, 0);
    chk("t6_rst_byte", bus.byte_out, 0);
    chk("t6_rst_busy", bus.busy, 0);
    chk("t6_rst_strobe", bus.rd_strobe, 0);
    chk("t6_rst_pulses", {bus.err_bad_addr, bus.err_timeout, bus.drop_pulse}, 0);
    chk("t6_sent_before_rst", exp_q.size(), 0);
    exp_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("t6_post_rst_quiet", bus.byte_out_valid, 0);
    push_word(32'hA5A5_0F0F);
    send_instr(8'h08);
    chk("t6_strobe", bus.rd_strobe, 4'b0100);
    tick();
    tick();
    bus.rd_valid = 1'b1;
    bus.rd_data  = 32'hA5A5_0F0F;
    tick();
    bus.rd_valid = 1'b0;
    chk("t6_byte0", bus.byte_out, 8'h0F);
    wait_idle("t6_idle");

    tick();
    chk("final_q", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
